// File: rtl/char_motion_ctrl.sv
// Character window position controller: once per frame, moves a CHAR_W x CHAR_H window
// on the button inputs with wrap-around, and generates a frame-based flash phase.
module char_motion_ctrl #(
    parameter int unsigned HDR          = 640,
    parameter int unsigned VDR          = 480,
    parameter int unsigned CHAR_W       = 8,
    parameter int unsigned CHAR_H       = 16,
    parameter int unsigned INIT_H       = 316,
    parameter int unsigned INIT_V       = 232,
    parameter int unsigned FLASH_FRAMES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] pixelCnt,
    input  logic [8:0] lineCnt,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic [3:0] stepSize,
    input  logic       flashEn,
    output logic [9:0] posHorStart,
    output logic [9:0] posHorEnd,
    output logic [8:0] posVerStart,
    output logic [8:0] posVerEnd,
    output logic       flashClk,
    output logic       posUpd
);

    localparam int unsigned FCW = ($clog2(FLASH_FRAMES) > 5) ? $clog2(FLASH_FRAMES) : 5;

    typedef enum logic [1:0] {StIdle, StCalc, StCommit} stateT;

    stateT          state;
    logic           lineAtEnd;
    logic           lineAtEndQ;
    logic           armed;
    logic           frameEvt;
    logic [FCW-1:0] flashCnt;
    logic           flashEnS;
    logic [9:0]     horStartS;
    logic [9:0]     horEndS;
    logic [8:0]     verStartS;
    logic [8:0]     verEndS;

    logic [9:0]  horNext;
    logic [9:0]  horEndNext;
    logic [8:0]  verNext;
    logic [8:0]  verEndNext;
    logic [10:0] horSum;
    logic [10:0] horDiff;
    logic [10:0] horEndSum;
    logic [9:0]  verSum;
    logic [9:0]  verDiff;
    logic [9:0]  verEndSum;

    // The pixel counter is part of the timing interface but plays no role in motion.
    logic unusedPixel;
    assign unusedPixel = ^pixelCnt;

    // armed blocks a spurious event when reset releases while lineCnt already sits at VDR.
    assign lineAtEnd = (lineCnt == 9'(VDR));
    assign frameEvt  = lineAtEnd && !lineAtEndQ && armed;

    always_comb begin
        horSum  = {1'b0, posHorStart} + 11'(stepSize);
        horDiff = {1'b0, posHorStart} - 11'(stepSize);
        horNext = posHorStart;
        if (btnRight && !btnLeft) begin
            horNext = (horSum >= 11'(HDR)) ? 10'(horSum - 11'(HDR)) : horSum[9:0];
        end else if (btnLeft && !btnRight) begin
            horNext = horDiff[10] ? 10'(horDiff + 11'(HDR)) : horDiff[9:0];
        end
        horEndSum  = {1'b0, horNext} + 11'(CHAR_W);
        horEndNext = (horEndSum >= 11'(HDR)) ? 10'(horEndSum - 11'(HDR)) : horEndSum[9:0];
    end

    always_comb begin
        verSum  = {1'b0, posVerStart} + 10'(stepSize);
        verDiff = {1'b0, posVerStart} - 10'(stepSize);
        verNext = posVerStart;
        if (btnDown && !btnUp) begin
            verNext = (verSum >= 10'(VDR)) ? 9'(verSum - 10'(VDR)) : verSum[8:0];
        end else if (btnUp && !btnDown) begin
            verNext = verDiff[9] ? 9'(verDiff + 10'(VDR)) : verDiff[8:0];
        end
        verEndSum  = {1'b0, verNext} + 10'(CHAR_H);
        verEndNext = (verEndSum >= 10'(VDR)) ? 9'(verEndSum - 10'(VDR)) : verEndSum[8:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            lineAtEndQ  <= 1'b0;
            armed       <= 1'b0;
            flashCnt    <= '0;
            flashEnS    <= 1'b0;
            flashClk    <= 1'b0;
            posUpd      <= 1'b0;
            posHorStart <= 10'(INIT_H);
            posHorEnd   <= 10'(INIT_H + CHAR_W);
            posVerStart <= 9'(INIT_V);
            posVerEnd   <= 9'(INIT_V + CHAR_H);
            horStartS   <= 10'(INIT_H);
            horEndS     <= 10'(INIT_H + CHAR_W);
            verStartS   <= 9'(INIT_V);
            verEndS     <= 9'(INIT_V + CHAR_H);
        end else begin
            lineAtEndQ <= lineAtEnd;
            if (!lineAtEnd) begin
                armed <= 1'b1;
            end
            posUpd <= 1'b0;
            case (state)
                StIdle: begin
                    if (frameEvt) begin
                        state <= StCalc;
                    end
                end
                StCalc: begin
                    horStartS <= horNext;
                    horEndS   <= horEndNext;
                    verStartS <= verNext;
                    verEndS   <= verEndNext;
                    flashEnS  <= flashEn;
                    state     <= StCommit;
                end
                StCommit: begin
                    posHorStart <= horStartS;
                    posHorEnd   <= horEndS;
                    posVerStart <= verStartS;
                    posVerEnd   <= verEndS;
                    posUpd      <= 1'b1;
                    if (!flashEnS) begin
                        flashCnt <= '0;
                        flashClk <= 1'b0;
                    end else if (flashCnt == FCW'(FLASH_FRAMES - 1)) begin
                        flashCnt <= '0;
                        flashClk <= !flashClk;
                    end else begin
                        flashCnt <= flashCnt + FCW'(1);
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Randomized scoreboard bench for char_motion_ctrl: stimulus pushes model predictions,
// a negedge monitor pops them on posUpd and checks outputs stay put in between.
module tb_char_motion_ctrl;

    localparam int HDR = 640;
    localparam int VDR = 480;
    localparam int CW  = 8;
    localparam int CH  = 16;
    localparam int IH  = 316;
    localparam int IV  = 232;
    localparam int FF  = 30;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] pixelCnt = '0;
    logic [8:0] lineCnt = 9'(VDR);
    logic       btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
    logic [3:0] stepSize = '0;
    logic       flashEn = 1'b0;
    logic [9:0] posHorStart, posHorEnd;
    logic [8:0] posVerStart, posVerEnd;
    logic       flashClk, posUpd;

    char_motion_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .pixelCnt   (pixelCnt),
        .lineCnt    (lineCnt),
        .btnUp      (btnUp),
        .btnDown    (btnDown),
        .btnLeft    (btnLeft),
        .btnRight   (btnRight),
        .stepSize   (stepSize),
        .flashEn    (flashEn),
        .posHorStart(posHorStart),
        .posHorEnd  (posHorEnd),
        .posVerStart(posVerStart),
        .posVerEnd  (posVerEnd),
        .flashClk   (flashClk),
        .posUpd     (posUpd)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int hs;
        int he;
        int vs;
        int ve;
        int fl;
        int due;
    } expT;

    expT q[$];
    int  nCmp = 0;
    int  nBad = 0;

    // Reference model: absolute positions and the length of the current flashEn run.
    int mh = IH;
    int mv = IV;
    int runLen = 0;

    function automatic void check(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nBad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic expT initExp();
        expT e;
        e.hs = IH; e.he = IH + CW; e.vs = IV; e.ve = IV + CH; e.fl = 0; e.due = 0;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic randInputs();
        {btnUp, btnDown, btnLeft, btnRight} = 4'($urandom);
        stepSize = 4'($urandom);
        flashEn  = 1'($urandom);
        pixelCnt = 10'($urandom_range(0, 799));
    endtask

    // One frame: random noise on the inputs, then the requested levels around the event.
    task automatic frame(input bit r, input bit l, input bit d, input bit u, input int step,
                         input bit fe, input int idle);
        expT e;
        repeat (idle) begin
            randInputs();
            lineCnt = 9'($urandom_range(0, VDR - 1));
            tick(1);
        end
        btnRight = r; btnLeft = l; btnDown = d; btnUp = u;
        stepSize = 4'(step);
        flashEn  = fe;
        lineCnt  = 9'd100;
        tick(1);
        lineCnt = 9'(VDR);
        if (r && !l) mh = (mh + step) % HDR;
        else if (l && !r) mh = (mh + HDR - step) % HDR;
        if (d && !u) mv = (mv + step) % VDR;
        else if (u && !d) mv = (mv + VDR - step) % VDR;
        runLen = fe ? runLen + 1 : 0;
        e.hs = mh; e.he = (mh + CW) % HDR;
        e.vs = mv; e.ve = (mv + CH) % VDR;
        e.fl = (runLen / FF) % 2;
        e.due = cyc + 3;
        q.push_back(e);
        tick(2);
        randInputs();
        tick(3);
        lineCnt = 9'($urandom_range(0, VDR - 1));
    endtask

    task automatic randFrame(input bit fe);
        frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 15), fe, $urandom_range(1, 6));
    endtask

    task automatic checkInit(input string tag);
        check({tag, " posHorStart"}, posHorStart, IH);
        check({tag, " posHorEnd"}, posHorEnd, IH + CW);
        check({tag, " posVerStart"}, posVerStart, IV);
        check({tag, " posVerEnd"}, posVerEnd, IV + CH);
        check({tag, " flashClk"}, flashClk, 0);
        check({tag, " posUpd"}, posUpd, 0);
    endtask

    // Reset pulse k cycles after the event cycle; the pending update must vanish.
    task automatic resetDuringFrame(input int k);
        btnRight = 1; btnLeft = 0; btnUp = 0; btnDown = 0;
        stepSize = 4'd4;
        flashEn  = 1;
        lineCnt  = 9'd100;
        tick(1);
        lineCnt = 9'(VDR);
        tick(k);
        reset = 0;
        mh = IH; mv = IV; runLen = 0;
        tick(2);
        checkInit("reset mid-frame");
        reset = 1;
        tick(6);
        check("no event after mid-frame reset", posHorStart, IH);
        lineCnt = 9'd0;
        tick(2);
    endtask

    // Monitor: checks each commit against the queue and output stability otherwise.
    initial begin
        expT cur;
        expT e;
        cur = initExp();
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                cur = initExp();
                q.delete();
            end else begin
                if (posUpd) begin
                    if (q.size() == 0) begin
                        check("unexpected posUpd", posUpd, 0);
                    end else begin
                        e = q.pop_front();
                        check("posUpd latency", cyc, e.due);
                        cur = e;
                    end
                end else if (q.size() > 0 && cyc > q[0].due) begin
                    check("missing posUpd", posUpd, 1);
                    cur = q.pop_front();
                end
                check("posHorStart", posHorStart, cur.hs);
                check("posHorEnd", posHorEnd, cur.he);
                check("posVerStart", posVerStart, cur.vs);
                check("posVerEnd", posVerEnd, cur.ve);
                check("flashClk", flashClk, cur.fl);
            end
        end
    end

    initial begin
        tick(3);
        checkInit("in reset");
        reset = 1;
        tick(6);
        checkInit("release at VDR");
        lineCnt = 9'd0;
        tick(2);

        repeat (3) frame(0, 0, 0, 0, 0, 0, 3);
        check("idle frames posHorStart", posHorStart, 316);

        for (int i = 1; i <= 3; i++) begin
            frame(1, 0, 0, 0, 4, 0, 3);
            check("step right", posHorStart, IH + 4 * i);
        end
        check("step right end", posHorEnd, 336);

        repeat (77) frame(1, 0, 0, 0, 4, 0, 2);
        check("reach 636", posHorStart, 636);
        frame(1, 0, 0, 0, 4, 0, 2);
        check("wrap right start", posHorStart, 0);
        check("wrap right end", posHorEnd, 8);
        frame(1, 0, 0, 0, 2, 0, 2);
        frame(0, 1, 0, 0, 4, 0, 2);
        check("wrap left start", posHorStart, 638);
        check("wrap left end", posHorEnd, 6);

        repeat (119) frame(0, 0, 1, 0, 2, 0, 2);
        check("reach 470", posVerStart, 470);
        frame(0, 0, 1, 0, 2, 0, 2);
        check("down start", posVerStart, 472);
        check("down wrapped end", posVerEnd, 8);
        frame(0, 0, 1, 1, 9, 0, 2);
        check("up+down hold", posVerStart, 472);

        for (int i = 1; i <= 60; i++) begin
            randFrame(1);
            if (i == 29) check("flash f29", flashClk, 0);
            if (i == 30) check("flash f30", flashClk, 1);
            if (i == 59) check("flash f59", flashClk, 1);
            if (i == 60) check("flash f60", flashClk, 0);
        end
        repeat (10) randFrame(1);
        randFrame(0);
        check("flash drop", flashClk, 0);
        for (int i = 1; i <= 30; i++) begin
            randFrame(1);
            if (i == 29) check("flash restart f29", flashClk, 0);
            if (i == 30) check("flash restart f30", flashClk, 1);
        end

        repeat (150) randFrame(1'(($urandom % 8) != 0));

        resetDuringFrame(1);
        repeat (3) randFrame(1);
        resetDuringFrame(2);
        repeat (5) randFrame(1);

        tick(5);
        check("queue drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
